// File: rtl/ulpi_init_sequencer_pkg.sv
// Shared definitions for the ULPI PHY init sequencer: FSM encoding,
// ULPI register addresses of the init table and small helpers.
package ulpi_init_sequencer_pkg;

  // Sequencer FSM states (also exported on the debug port).
  typedef enum logic [3:0] {
    ST_STARTUP = 4'd0,
    ST_WR_REQ  = 4'd1,
    ST_WR_WAIT = 4'd2,
    ST_RD_REQ  = 4'd3,
    ST_RD_WAIT = 4'd4,
    ST_CHECK   = 4'd5,
    ST_DONE    = 4'd6,
    ST_ERROR   = 4'd7
  } state_e;

  // USB3300 / ULPI immediate register addresses used by the init table.
  localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
  localparam logic [5:0] ADDR_IFC_CTRL  = 6'h07;
  localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;

  // Index of the last init-table entry.
  localparam logic [1:0] LAST_IDX = 2'd2;

  // Width of the per-state handshake timeout counter.
  localparam int TO_CNT_W = 8;

  // Saturating increment for the timeout counter.
  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    return (v == {TO_CNT_W{1'b1}}) ? v : v + TO_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ulpi_init_rom.sv
// Init table: maps an entry index to the ULPI register address and the
// value that must be written there for passive full-speed sniffing.
module ulpi_init_rom
  import ulpi_init_sequencer_pkg::*;
#(
  parameter logic [7:0] FUNC_CTRL_VAL = 8'h49,
  parameter logic [7:0] IFC_CTRL_VAL  = 8'h00,
  parameter logic [7:0] OTG_CTRL_VAL  = 8'h00
) (
  input  logic [1:0] idx_i,
  output logic [5:0] addr_o,
  output logic [7:0] data_o
);

  // Pure lookup; unused index 3 returns zeros.
  always_comb begin
    addr_o = 6'h00;
    data_o = 8'h00;
    case (idx_i)
      2'd0: begin
        addr_o = ADDR_FUNC_CTRL;
        data_o = FUNC_CTRL_VAL;
      end
      2'd1: begin
        addr_o = ADDR_IFC_CTRL;
        data_o = IFC_CTRL_VAL;
      end
      2'd2: begin
        addr_o = ADDR_OTG_CTRL;
        data_o = OTG_CTRL_VAL;
      end
      default: begin
        addr_o = 6'h00;
        data_o = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/ulpi_init_sequencer.sv
// ULPI PHY init sequencer: after a settle delay, writes the init table
// through the ULPI wrapper register port, reads each entry back, retries
// on timeout or mismatch and reports done / error.
//
// Register-access handshake with the wrapper: a request (WD or RD) is
// raised only in a cycle where busy is sampled low, held until busy is
// sampled high (then dropped on the following edge), and the access is
// complete at the first sampled busy low after that. A request that sees
// no busy rise, or a busy that never falls, within TIMEOUT_CYCLES fails.
module ulpi_init_sequencer
  import ulpi_init_sequencer_pkg::*;
#(
  parameter int         STARTUP_CYCLES = 1024,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         MAX_RETRIES    = 3,
  parameter logic [7:0] FUNC_CTRL_VAL  = 8'h49,
  parameter logic [7:0] IFC_CTRL_VAL   = 8'h00,
  parameter logic [7:0] OTG_CTRL_VAL   = 8'h00
) (
  input  logic       clk_int,
  input  logic       rst,
  input  logic       start,
  input  logic       busy,
  input  logic [7:0] REG_DATA_OUT,
  output logic       WD,
  output logic       RD,
  output logic [5:0] ADDR,
  output logic [7:0] REG_DATA_IN,
  output logic       done,
  output logic       error,
  output logic [5:0] err_addr,
  output logic [3:0] dbg_state_o
);

  localparam int SU_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam logic [SU_W-1:0] SU_LAST =
    SU_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
  localparam logic [TO_CNT_W-1:0] TO_LAST =
    TO_CNT_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);
  localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRIES);

  state_e              state_q, state_d;
  logic [SU_W-1:0]     su_cnt_q, su_cnt_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [RT_W-1:0]     retry_q, retry_d;
  logic                wd_q, wd_d;
  logic                rd_q, rd_d;
  logic [5:0]          addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [5:0]          err_addr_q, err_addr_d;
  logic                fail;

  logic [5:0] rom_addr;
  logic [7:0] rom_data;

  ulpi_init_rom #(
    .FUNC_CTRL_VAL (FUNC_CTRL_VAL),
    .IFC_CTRL_VAL  (IFC_CTRL_VAL),
    .OTG_CTRL_VAL  (OTG_CTRL_VAL)
  ) u_rom (
    .idx_i  (idx_q),
    .addr_o (rom_addr),
    .data_o (rom_data)
  );

  // Next-state, counters and registered-output logic.
  always_comb begin
    state_d    = state_q;
    su_cnt_d   = su_cnt_q;
    to_cnt_d   = to_cnt_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    wd_d       = wd_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    fail       = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        wd_d = 1'b0;
        rd_d = 1'b0;
        if (su_cnt_q >= SU_LAST) begin
          su_cnt_d = '0;
          idx_d    = 2'd0;
          retry_d  = '0;
          state_d  = ST_WR_REQ;
        end else begin
          su_cnt_d = su_cnt_q + SU_W'(1);
        end
      end

      ST_WR_REQ: begin
        if (!wd_q) begin
          // Never launch a write while the wrapper is still busy.
          if (!busy) begin
            wd_d    = 1'b1;
            addr_d  = rom_addr;
            wdata_d = rom_data;
          end
        end else if (busy) begin
          wd_d    = 1'b0;
          state_d = ST_WR_WAIT;
        end else if (to_cnt_q >= TO_LAST) begin
          wd_d = 1'b0;
          fail = 1'b1;
        end else begin
          to_cnt_d = sat_inc(to_cnt_q);
        end
      end

      ST_WR_WAIT: begin
        if (!busy) begin
          state_d = ST_RD_REQ;
        end else if (to_cnt_q >= TO_LAST) begin
          fail = 1'b1;
        end else begin
          to_cnt_d = sat_inc(to_cnt_q);
        end
      end

      ST_RD_REQ: begin
        if (!rd_q) begin
          if (!busy) begin
            rd_d   = 1'b1;
            addr_d = rom_addr;
          end
        end else if (busy) begin
          rd_d    = 1'b0;
          state_d = ST_RD_WAIT;
        end else if (to_cnt_q >= TO_LAST) begin
          rd_d = 1'b0;
          fail = 1'b1;
        end else begin
          to_cnt_d = sat_inc(to_cnt_q);
        end
      end

      ST_RD_WAIT: begin
        if (!busy) begin
          // Readback is valid in the first cycle busy is seen low.
          rdata_d = REG_DATA_OUT;
          state_d = ST_CHECK;
        end else if (to_cnt_q >= TO_LAST) begin
          fail = 1'b1;
        end else begin
          to_cnt_d = sat_inc(to_cnt_q);
        end
      end

      ST_CHECK: begin
        if (rdata_q == rom_data) begin
          retry_d = '0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_WR_REQ;
          end
        end else begin
          fail = 1'b1;
        end
      end

      ST_DONE, ST_ERROR: begin
        wd_d = 1'b0;
        rd_d = 1'b0;
        if (start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = 6'h00;
          su_cnt_d   = '0;
          idx_d      = 2'd0;
          retry_d    = '0;
          state_d    = ST_STARTUP;
        end
      end

      default: begin
        wd_d    = 1'b0;
        rd_d    = 1'b0;
        state_d = ST_STARTUP;
      end
    endcase

    // A failed attempt either retries the same entry from its write or,
    // once the retry budget is spent, latches the failing address.
    if (fail) begin
      if (retry_q < RT_MAX) begin
        retry_d = retry_q + RT_W'(1);
        state_d = ST_WR_REQ;
      end else begin
        error_d    = 1'b1;
        err_addr_d = rom_addr;
        state_d    = ST_ERROR;
      end
    end

    // The timeout counter measures time spent in the current state only.
    if (fail || (state_d != state_q)) begin
      to_cnt_d = '0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_int or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_STARTUP;
      su_cnt_q   <= '0;
      to_cnt_q   <= '0;
      idx_q      <= 2'd0;
      retry_q    <= '0;
      wd_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= 6'h00;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= 6'h00;
    end else begin
      state_q    <= state_d;
      su_cnt_q   <= su_cnt_d;
      to_cnt_q   <= to_cnt_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      wd_q       <= wd_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign WD          = wd_q;
  assign RD          = rd_q;
  assign ADDR        = addr_q;
  assign REG_DATA_IN = wdata_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_addr    = err_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ulpi_init_sequencer.sv
// Bench for ulpi_init_sequencer with a behavioural ULPI register model.
module tb_ulpi_init_sequencer;
  import ulpi_init_sequencer_pkg::*;

  localparam int W = 15;  // {is_read, addr[5:0], data[7:0]}

  logic       clk_int = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy = 1'b0;
  logic [7:0] REG_DATA_OUT = 8'h00;
  logic       WD, RD, done, error;
  logic [5:0] ADDR, err_addr;
  logic [7:0] REG_DATA_IN;
  logic [3:0] dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int viol_cnt = 0;

  // Model controls set by the tests.
  bit         stuck = 1'b0;
  int         force_cnt = 0;
  logic [5:0] mm_addr = 6'h00;
  int         mm_cnt = 0;

  // Model state.
  logic [7:0] mem [64];
  int         busy_cnt = 0;
  bit         op_rd = 1'b0;
  logic [5:0] op_addr = 6'h00;
  logic       prev_wd = 1'b0, prev_rd = 1'b0;
  logic       new_wd, new_rd;
  bit         forcing;

  ulpi_init_sequencer #(
    .STARTUP_CYCLES (16)
  ) dut (
    .clk_int      (clk_int),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .REG_DATA_OUT (REG_DATA_OUT),
    .WD           (WD),
    .RD           (RD),
    .ADDR         (ADDR),
    .REG_DATA_IN  (REG_DATA_IN),
    .done         (done),
    .error        (error),
    .err_addr     (err_addr),
    .dbg_state_o  (dbg_state)
  );

  // Clock.
  initial forever #5 clk_int = ~clk_int;

  // ULPI register model, updated on the falling edge.
  initial begin
    forever begin
      @(negedge clk_int);
      if (!rst) begin
        busy = 1'b0;
        busy_cnt = 0;
        prev_wd = 1'b0;
        prev_rd = 1'b0;
        REG_DATA_OUT = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'hA5;
      end else begin
        if (WD && RD) viol_cnt++;
        new_wd = WD && !prev_wd;
        new_rd = RD && !prev_rd;
        if ((new_wd || new_rd) && busy) viol_cnt++;
        if (new_wd) obs_q.push_back({1'b0, ADDR, REG_DATA_IN});
        if (new_rd) obs_q.push_back({1'b1, ADDR, 8'h00});
        prev_wd = WD;
        prev_rd = RD;
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0 && op_rd) begin
            if (op_addr == mm_addr && mm_cnt > 0) begin
              REG_DATA_OUT = 8'h48;
              mm_cnt--;
            end else begin
              REG_DATA_OUT = mem[op_addr];
            end
          end
        end else if ((new_wd || new_rd) && !stuck) begin
          busy_cnt = 4;
          op_rd = new_rd;
          op_addr = ADDR;
          if (new_wd) mem[ADDR] = REG_DATA_IN;
        end
        forcing = (force_cnt > 0);
        if (forcing) force_cnt--;
        busy = (busy_cnt > 0) || forcing;
      end
    end
  end

  // Driver: hold reset for a few cycles, release on a falling edge.
  task automatic do_reset();
    @(negedge clk_int);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk_int);
    obs_q.delete();
    exp_q.delete();
    rst = 1'b1;
  endtask

  // Driver: one-cycle start pulse.
  task automatic pulse_start();
    @(negedge clk_int);
    start = 1'b1;
    @(negedge clk_int);
    start = 1'b0;
  endtask

  // Bounded wait for done or error.
  task automatic wait_end(input int budget, output bit timed_out);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(posedge clk_int);
      #1;
      n++;
    end
    timed_out = !(done || error);
  endtask

  task automatic push_nominal();
    exp_q.push_back({1'b0, 6'h04, 8'h49});
    exp_q.push_back({1'b1, 6'h04, 8'h00});
    exp_q.push_back({1'b0, 6'h07, 8'h00});
    exp_q.push_back({1'b1, 6'h07, 8'h00});
    exp_q.push_back({1'b0, 6'h0A, 8'h00});
    exp_q.push_back({1'b1, 6'h0A, 8'h00});
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    #3;
    rst = 1'b0;
    #1;
    outs = {WD, RD, ADDR, REG_DATA_IN, done, error, err_addr};
    chk_cnt++;
    if (outs !== 24'h0) $display("FAIL reset_outputs: got %h want 000000", outs);
    else pass_cnt++;
    chk_cnt++;
    if (dbg_state !== ST_STARTUP) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_STARTUP);
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    int first;
    bit to;
    logic [W-1:0] e, o;
    do_reset();
    push_nominal();
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      @(posedge clk_int);
      #1;
      if (WD || RD) first = i;
    end
    chk_cnt++;
    if (first !== 17) $display("FAIL nominal_first_wd: got edge %0d want 17", first);
    else pass_cnt++;
    wait_end(3000, to);
    repeat (20) @(posedge clk_int);
    #1;
    chk_cnt++;
    if (to !== 1'b0) $display("FAIL nominal_timeout: got %0b want 0", to);
    else pass_cnt++;
    chk_cnt++;
    if ({done, error} !== 2'b10) $display("FAIL nominal_flags: got %b want 10", {done, error});
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL nominal_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk_cnt++;
      if (o !== e) $display("FAIL nominal_access: got %h want %h", o, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_mismatch_once();
    bit to;
    logic [W-1:0] e, o;
    mm_addr = 6'h04;
    mm_cnt = 1;
    do_reset();
    exp_q.push_back({1'b0, 6'h04, 8'h49});
    exp_q.push_back({1'b1, 6'h04, 8'h00});
    push_nominal();
    wait_end(3000, to);
    repeat (20) @(posedge clk_int);
    #1;
    chk_cnt++;
    if ({to, done, error} !== 3'b010) $display("FAIL mismatch_once_flags: got %b want 010", {to, done, error});
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL mismatch_once_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk_cnt++;
      if (o !== e) $display("FAIL mismatch_once_access: got %h want %h", o, e);
      else pass_cnt++;
    end
    mm_cnt = 0;
  endtask

  task automatic test_persistent_mismatch();
    bit to;
    logic [W-1:0] e, o;
    mm_addr = 6'h07;
    mm_cnt = 100;
    do_reset();
    exp_q.push_back({1'b0, 6'h04, 8'h49});
    exp_q.push_back({1'b1, 6'h04, 8'h00});
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b0, 6'h07, 8'h00});
      exp_q.push_back({1'b1, 6'h07, 8'h00});
    end
    wait_end(3000, to);
    repeat (20) @(posedge clk_int);
    #1;
    chk_cnt++;
    if ({to, done, error} !== 3'b001) $display("FAIL persist_flags: got %b want 001", {to, done, error});
    else pass_cnt++;
    chk_cnt++;
    if (err_addr !== 6'h07) $display("FAIL persist_err_addr: got %h want 07", err_addr);
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL persist_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk_cnt++;
      if (o !== e) $display("FAIL persist_access: got %h want %h", o, e);
      else pass_cnt++;
    end
    mm_cnt = 0;
  endtask

  task automatic test_busy_stuck();
    bit to;
    int hold;
    int guard;
    logic [W-1:0] e, o;
    stuck = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 6'h04, 8'h49});
    guard = 0;
    while (!WD && guard < 40) begin
      @(posedge clk_int);
      #1;
      guard++;
    end
    hold = 0;
    while (WD && hold < 400) begin
      hold++;
      @(posedge clk_int);
      #1;
    end
    chk_cnt++;
    if (hold !== 255) $display("FAIL stuck_wd_hold: got %0d cycles want 255", hold);
    else pass_cnt++;
    wait_end(3000, to);
    repeat (20) @(posedge clk_int);
    #1;
    chk_cnt++;
    if ({to, done, error} !== 3'b001) $display("FAIL stuck_flags: got %b want 001", {to, done, error});
    else pass_cnt++;
    chk_cnt++;
    if (err_addr !== 6'h04) $display("FAIL stuck_err_addr: got %h want 04", err_addr);
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL stuck_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk_cnt++;
      if (o !== e) $display("FAIL stuck_access: got %h want %h", o, e);
      else pass_cnt++;
    end
    stuck = 1'b0;
  endtask

  task automatic test_busy_at_request();
    int first;
    bit to;
    logic [W-1:0] e, o;
    do_reset();
    push_nominal();
    first = 0;
    for (int i = 1; i <= 60 && first == 0; i++) begin
      @(posedge clk_int);
      #1;
      if (i == 16) force_cnt = 10;
      if (WD || RD) first = i;
    end
    chk_cnt++;
    if (first !== 27) $display("FAIL busy_req_first_wd: got edge %0d want 27", first);
    else pass_cnt++;
    wait_end(3000, to);
    repeat (20) @(posedge clk_int);
    #1;
    chk_cnt++;
    if ({to, done, error} !== 3'b010) $display("FAIL busy_req_flags: got %b want 010", {to, done, error});
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL busy_req_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk_cnt++;
      if (o !== e) $display("FAIL busy_req_access: got %h want %h", o, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_restart();
    bit to;
    int guard;
    logic [23:0] outs;
    logic [W-1:0] e, o;
    do_reset();
    guard = 0;
    while (!(RD && ADDR == 6'h0A) && guard < 400) begin
      @(posedge clk_int);
      #1;
      guard++;
    end
    chk_cnt++;
    if (RD !== 1'b1) $display("FAIL restart_reach_rd: got RD=%b want 1", RD);
    else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    outs = {WD, RD, ADDR, REG_DATA_IN, done, error, err_addr};
    chk_cnt++;
    if (outs !== 24'h0) $display("FAIL restart_async_reset: got %h want 000000", outs);
    else pass_cnt++;
    // Full rerun after release.
    do_reset();
    push_nominal();
    wait_end(3000, to);
    repeat (10) @(posedge clk_int);
    #1;
    chk_cnt++;
    if ({to, done, error} !== 3'b010) $display("FAIL restart_rerun_flags: got %b want 010", {to, done, error});
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL restart_rerun_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk_cnt++;
      if (o !== e) $display("FAIL restart_rerun_access: got %h want %h", o, e);
      else pass_cnt++;
    end
    // start in DONE clears done and reruns; a later start mid-run is ignored.
    obs_q.delete();
    push_nominal();
    @(negedge clk_int);
    start = 1'b1;
    @(posedge clk_int);
    #1;
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL start_clears_done: got %b want 0", done);
    else pass_cnt++;
    @(negedge clk_int);
    start = 1'b0;
    repeat (30) @(posedge clk_int);
    pulse_start();
    wait_end(3000, to);
    repeat (20) @(posedge clk_int);
    #1;
    chk_cnt++;
    if ({to, done, error} !== 3'b010) $display("FAIL start_rerun_flags: got %b want 010", {to, done, error});
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL start_rerun_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk_cnt++;
      if (o !== e) $display("FAIL start_rerun_access: got %h want %h", o, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_protocol();
    chk_cnt++;
    if (viol_cnt !== 0) $display("FAIL protocol_violations: got %0d want 0", viol_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mismatch_once();
    test_persistent_mismatch();
    test_busy_stuck();
    test_busy_at_request();
    test_reset_restart();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
